// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// States, owner encoding and wait-state counter sizing.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_AUX
  } owner_t;

  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between requesters, arbiter and memory macro.
// master = requester/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_ready_o;

  logic              aux_req_i;
  logic              aux_we_i;
  logic [ADDR_W-1:0] aux_addr_i;
  logic [DATA_W-1:0] aux_wdata_i;
  logic [DATA_W-1:0] aux_rdata_o;
  logic              aux_ready_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output cpu_req_i, cpu_we_i,
    output cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_ready_o,
    output aux_req_i, aux_we_i,
    output aux_addr_i, aux_wdata_i,
    input  aux_rdata_o, aux_ready_o,
    input  mem_req_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

  modport slave (
    input  cpu_req_i, cpu_we_i,
    input  cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_ready_o,
    input  aux_req_i, aux_we_i,
    input  aux_addr_i, aux_wdata_i,
    output aux_rdata_o, aux_ready_o,
    output mem_req_o, mem_we_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_ws_counter.sv
// Memory wait-state counter: load, decrement to zero, zero flag.
// Saturates at zero so it never wraps.
module ws_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load on grant, count down while the access is in progress.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified I/D memory between CPU and AUX.
// IDLE grants, ACCESS holds the bus for the wait states, DONE pulses ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 2,
  parameter int ARB_MODE    = 0
) (
  input logic               clk_i,
  input logic               reset_i,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = cnt_width(WAIT_STATES);
  localparam logic [CW-1:0] WS_LD = CW'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  arb_state_t state;
  owner_t     owner;
  owner_t     last_owner;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] aux_rdata_q;
  logic              cpu_ready_q;
  logic              aux_ready_q;
  logic              mem_req_q;
  logic              mem_we_q;

  logic              cpu_req;
  logic              aux_req;
  logic              grant;
  logic              grant_cpu;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  assign cpu_req = bus.cpu_req_i;
  assign aux_req = bus.aux_req_i;
  assign grant   = cpu_req | aux_req;

  // Pick the winner; a tie goes by mode and the previous owner.
  always_comb begin
    grant_cpu = 1'b0;
    unique case (1'b1)
      (cpu_req && aux_req):
        grant_cpu = (ARB_MODE != 0) ||
                    (last_owner == OWN_AUX);
      (cpu_req && !aux_req):
        grant_cpu = 1'b1;
      default:
        grant_cpu = 1'b0;
    endcase
  end

  assign sel_we    = grant_cpu ? bus.cpu_we_i
                               : bus.aux_we_i;
  assign sel_addr  = grant_cpu ? bus.cpu_addr_i
                               : bus.aux_addr_i;
  assign sel_wdata = grant_cpu ? bus.cpu_wdata_i
                               : bus.aux_wdata_i;

  assign cnt_load = (state == ARB_IDLE) && grant;
  assign cnt_dec  = (state == ARB_ACCESS);

  ws_counter #(
    .W (CW)
  ) u_ws_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WS_LD),
    .zero     (cnt_zero)
  );

  // Transaction FSM with latched request and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ARB_IDLE;
      owner       <= OWN_CPU;
      last_owner  <= OWN_AUX;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      aux_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      aux_ready_q <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (grant) begin
            owner      <= grant_cpu ? OWN_CPU : OWN_AUX;
            last_owner <= grant_cpu ? OWN_CPU : OWN_AUX;
            we_q       <= sel_we;
            addr_q     <= sel_addr & ADDR_MASK;
            wdata_q    <= sel_wdata;
            mem_req_q  <= 1'b1;
            mem_we_q   <= sel_we;
            state      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt_zero) begin
            if (owner == OWN_CPU) begin
              cpu_ready_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= bus.mem_rdata_i;
            end else begin
              aux_ready_q <= 1'b1;
              if (!we_q) aux_rdata_q <= bus.mem_rdata_i;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata_o = cpu_rdata_q;
  assign bus.cpu_ready_o = cpu_ready_q;
  assign bus.aux_rdata_o = aux_rdata_q;
  assign bus.aux_ready_o = aux_ready_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule
